board_sync_gen: RTL
===================

Name: board_sync_gen

Overview:
Parametrised next-generation board synchroniser. It generates an n-high-in-m tick pattern for external devices such as a DC-coupled digitiser. In master mode it drives the pattern to a second FONT5 board. In slave mode it phase-locks its local counter to the remote pattern, reports lock, and counts alignment errors. It sits between the timing/trigger logic (source of toggle_en) and the top-level sync tristate pad, which lives at top level.

Parameters:
CNT_W, 4, width of pattern counter and cnt_n/cnt_m
SYNC_STAGES, 2, synchroniser flops on toggle_en and sync_i (min 2)
LOCK_COUNT, 4, consecutive matching remote edges required to assert locked (1..255)
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
synch_en  in  1  enable pattern generation
toggle_en  in  1  async tick source; rising edge advances pattern
cnt_n  in  CNT_W  pattern fall phase
cnt_m  in  CNT_W  pattern terminal count (period cnt_m+1 ticks)
op_mode  in  1  1 = master, 0 = slave (fail-safe default)
err_clr  in  1  synchronous clear of err_cnt
sync_i  in  1  pad input from remote board
sync_o  out  1  pad output data (local pattern)
sync_oe  out  1  pad output enable; equals op_mode
sync_local  out  1  local pattern for digitiser, both modes
synchroStatus  out  1  master: local pattern; slave: synchronised sync_i
locked  out  1  slave phase lock achieved
err_cnt  out  ERR_W  saturating count of slave misalignments

Behaviour:
- Reset (rst_n low, async): all flops 0. ctr=0, synch=0, sync_o=0, sync_oe=0, synchroStatus=0, locked=0, err_cnt=0, match_cnt=0.
- tick: toggle_en passes through SYNC_STAGES flops. tick is a registered one-cycle pulse on the rising edge of the synchronised level. Latency from first clk sampling toggle_en high to tick high is SYNC_STAGES+1 cycles. A held-high toggle_en gives exactly one tick.
- Counter, on tick only: ctr <= (ctr >= cnt_m) ? 0 : ctr+1. Using >= means a runtime reduction of cnt_m wraps on the next tick.
- Pattern, on tick only:
  - synch_en=0: synch <= 0.
  - Otherwise: if ctr==cnt_m, synch <= 1; else if ctr==cnt_n, synch <= 0; else hold.
  - Set has priority when cnt_n==cnt_m.
  - cnt_n<cnt_m: high for cnt_n+1 of every cnt_m+1 ticks.
  - cnt_n>cnt_m: synch stays high once set.
- sync_local = sync_o = synch, registered, with no added latency. sync_oe = op_mode.
- synchroStatus is registered each clk: op_mode ? synch : rs. rs is sync_i after SYNC_STAGES flops.
- Slave alignment (op_mode=0), evaluated on tick:
  - r_edge = rs & ~rs_at_prev_tick. rs_at_prev_tick is captured every tick.
  - r_edge with ctr==0: match. match_cnt++ (saturates at LOCK_COUNT); locked <= 1 when match_cnt reaches LOCK_COUNT.
  - r_edge with ctr!=0: realign ctr <= 1 (overrides normal increment). match_cnt <= 0, locked <= 0, err_cnt++ (saturating at all-ones).
  - No r_edge while ctr==0: missed edge. match_cnt <= 0, locked <= 0, err_cnt++.
  - With synch_en=0, the no-r_edge-at-ctr==0 (missed-edge) case is not checked.
- Master mode: locked=0, match_cnt=0, and err_cnt holds.
- op_mode change: takes effect next clk. match_cnt, locked and rs_at_prev_tick are cleared. ctr and err_cnt are kept.
- err_clr: err_cnt <= 0 next clk. It has priority over a simultaneous increment.
- cnt_n, cnt_m and synch_en are quasi-static but may change at any time; they are sampled only at ticks.

Decomposition:
- Package board_sync_pkg holds:
  - constants MODE_SLAVE=1'b0 and MODE_MASTER=1'b1;
  - default CNT_W/SYNC_STAGES/LOCK_COUNT/ERR_W;
  - a function sat_inc(value, width).
- One sub-module, sync_edge_det: SYNC_STAGES-flop synchroniser on an async input, outputting both the synchronised level and a registered rising-edge pulse. It is instantiated for toggle_en (pulse used) and sync_i (level used).

Test Plan:
- Master, cnt_m=3, cnt_n=1, synch_en=1, toggle_en pulse every 10 clk -> sync_o rises at tick 4 (ctr 3->0), falls at tick 6; period 4 ticks, high 2; sync_oe=1; tick appears 3 clk after toggle_en rise.
- Master, synch_en dropped mid-high -> sync_o=0 at next tick, not before; ctr keeps counting. cnt_n=5 with cnt_m=3 -> sync_o stays 1.
- Two instances back-to-back (master sync_o -> slave sync_i), cnt_m=3, LOCK_COUNT=4, slave ctr preloaded out of phase -> one err_cnt increment and realign; locked=1 after 4 further aligned periods; sync_local of both identical within SYNC_STAGES+1 clk.
- Locked slave, master sync held low for 2 periods -> locked=0, err_cnt+2; relocks after 4 good edges.
- err_cnt at 255 plus further misses -> stays 255; err_clr with a coincident miss -> 0.
- Reset asserted mid-pattern (sync_o=1, locked=1) -> all outputs 0 immediately, without waiting for a clk edge; the first tick after release advances ctr to 1.

Source files
------------

// File: rtl/board_sync_pkg.sv
// Shared constants and helpers for the board synchroniser.
// Mode encodings, default parameter values and a saturating increment.
package board_sync_pkg;

    localparam logic MODE_SLAVE  = 1'b0;
    localparam logic MODE_MASTER = 1'b1;

    localparam int unsigned DEF_CNT_W       = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_LOCK_COUNT  = 4;
    localparam int unsigned DEF_ERR_W       = 8;

    // Increment value, saturating at the all-ones code of the given width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/board_sync_gen_edge.sv
// Multi-flop synchroniser for an asynchronous input.
// Provides the synchronised level and a registered one-cycle rising-edge pulse.
module sync_edge_det
    import board_sync_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain   <= '0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            chain   <= {chain[STAGES-2:0], async_in};
            level_d <= chain[STAGES-1];
            rise    <= chain[STAGES-1] & ~level_d;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/board_sync_gen.sv
// Board synchroniser: generates an n-high-in-m tick pattern (master) or
// phase-locks the local pattern counter to a remote board's pattern (slave).
module board_sync_gen
    import board_sync_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned ERR_W       = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             synch_en,
    input  logic             toggle_en,
    input  logic [CNT_W-1:0] cnt_n,
    input  logic [CNT_W-1:0] cnt_m,
    input  logic             op_mode,
    input  logic             err_clr,
    input  logic             sync_i,
    output logic             sync_o,
    output logic             sync_oe,
    output logic             sync_local,
    output logic             synchroStatus,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0] LOCK_MAX = 8'(LOCK_COUNT);

    logic             tick;
    logic             tog_level_unused;
    logic             rs;
    logic             rs_rise_unused;
    logic [CNT_W-1:0] ctr;
    logic             synch;
    logic             rs_prev;
    logic [7:0]       match_cnt;
    logic             op_mode_q;
    logic             r_edge;
    logic             slave_act;
    logic             realign;
    logic             match;
    logic             miss;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_tog_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (toggle_en),
        .level    (tog_level_unused),
        .rise     (tick)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_rem_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sync_i),
        .level    (rs),
        .rise     (rs_rise_unused)
    );

    // Slave checks are suppressed on the cycle a mode change is being absorbed.
    always_comb begin
        r_edge    = rs & ~rs_prev;
        slave_act = tick && (op_mode == MODE_SLAVE) && (op_mode == op_mode_q);
        realign   = slave_act && r_edge && (ctr != '0);
        match     = slave_act && r_edge && (ctr == '0);
        miss      = slave_act && !r_edge && (ctr == '0) && synch_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr           <= '0;
            synch         <= 1'b0;
            rs_prev       <= 1'b0;
            match_cnt     <= '0;
            op_mode_q     <= 1'b0;
            sync_oe       <= 1'b0;
            synchroStatus <= 1'b0;
            locked        <= 1'b0;
            err_cnt       <= '0;
        end else begin
            op_mode_q     <= op_mode;
            sync_oe       <= op_mode;
            synchroStatus <= (op_mode == MODE_MASTER) ? synch : rs;

            if (tick) begin
                if (realign)
                    ctr <= CNT_W'(1);
                else
                    ctr <= (ctr >= cnt_m) ? '0 : ctr + 1'b1;

                if (!synch_en)
                    synch <= 1'b0;
                else if (ctr == cnt_m)
                    synch <= 1'b1;
                else if (ctr == cnt_n)
                    synch <= 1'b0;
            end

            if (op_mode != op_mode_q) begin
                match_cnt <= '0;
                locked    <= 1'b0;
                rs_prev   <= 1'b0;
            end else begin
                if (tick)
                    rs_prev <= rs;
                if (op_mode == MODE_MASTER) begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end else if (match) begin
                    if (match_cnt < LOCK_MAX)
                        match_cnt <= match_cnt + 8'd1;
                    if (match_cnt >= LOCK_MAX - 8'd1)
                        locked <= 1'b1;
                end else if (realign || miss) begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end

            if (err_clr)
                err_cnt <= '0;
            else if (realign || miss)
                err_cnt <= ERR_W'(sat_inc(32'(err_cnt), ERR_W));
        end
    end

    assign sync_o     = synch;
    assign sync_local = synch;

endmodule
